mtpsa_sdnet_to_sume: RTL

Re-joins the SDNet user pipeline's output streams into a single SUME AXI-Stream. It takes the `packet_out` beat stream and the per-packet `tuple_out` metadata and digest tuples, and emits a stream whose `m_axis_tuser` carries `{digest, mtpsa metadata}` on every beat of the matching packet. It sits between each `userNSwitch` instance and the downstream SUME output logic. It absorbs the arbitrary skew between tuple and packet by queuing tuples in a small FIFO and stalling packet beats until their tuple is present.

---
 rtl/mtpsa_sdnet_to_sume.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mtpsa_sdnet_to_sume.sv
// Joins the SDNet packet_out stream with its per-packet metadata/digest tuples
// into one SUME AXI-Stream; tuples queue in a small FIFO, packets stall until theirs arrives.
module mtpsa_sdnet_to_sume #(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_TUPLE_WIDTH     = 40,
  parameter int DIGEST_WIDTH      = 256,
  parameter int TUPLE_FIFO_DEPTH  = 4
) (
  input  logic                                  clk_line,
  input  logic                                  clk_line_rst,

  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  input  logic [C_AXIS_DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]        s_axis_tkeep,

  input  logic                                  tuple_mtpsa_valid,
  input  logic [C_TUPLE_WIDTH-1:0]              tuple_mtpsa_data,
  input  logic                                  tuple_digest_valid,
  input  logic [DIGEST_WIDTH-1:0]               tuple_digest_data,

  output logic [C_AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]        m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic [DIGEST_WIDTH+C_TUPLE_WIDTH-1:0] m_axis_tuser,

  output logic                                  tuple_overflow,
  output logic                                  digest_missing,
  output logic [31:0]                           pkt_count
);

  localparam int TUSER_W = DIGEST_WIDTH + C_TUPLE_WIDTH;
  localparam int PTR_W   = $clog2(TUPLE_FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(TUPLE_FIFO_DEPTH);

  typedef enum logic {
    WAIT_TUPLE = 1'b0,
    PASS       = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [TUSER_W-1:0]  fifo_mem [TUPLE_FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                fifo_full;

  logic [TUSER_W-1:0]  push_entry;
  logic [TUSER_W-1:0]  tuser_reg;
  logic                push;
  logic                push_accept;
  logic                pop;
  logic                pkt_done;

  // ---------------------------------------------------------------------------
  // Tuple capture. A digest strobe on its own carries no packet and is dropped.
  // ---------------------------------------------------------------------------
  assign push       = tuple_mtpsa_valid;
  assign push_entry = {(tuple_digest_valid ? tuple_digest_data : {DIGEST_WIDTH{1'b0}}),
                       tuple_mtpsa_data};

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_LEVEL);

  // A pop in the same cycle frees the slot the push lands in, so a full FIFO
  // still accepts the push.
  assign push_accept = push && (!fifo_full || pop);

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_line) begin
    // NOTE: registered state is written with <= so every flop samples the
    // pre-edge values of its neighbours, exactly as the hardware does.
    if (clk_line_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)         rd_ptr <= rd_ptr + 1'b1;
      case ({push_accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides what is
  // valid, and leaving it out keeps the array mappable to distributed RAM.
  always_ff @(posedge clk_line) begin
    if (push_accept) fifo_mem[wr_ptr] <= push_entry;
  end

  // ---------------------------------------------------------------------------
  // Packet state machine: next state and handshake routing
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next    = state;
    pop           = 1'b0;
    pkt_done      = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;

    case (state)
      WAIT_TUPLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = PASS;
        end
      end
      PASS: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          pkt_done   = 1'b1;
          state_next = WAIT_TUPLE;
        end
      end
    endcase
  end

  // When full, wr_ptr == rd_ptr; the pop reads the old entry because the
  // memory write only lands after this edge.
  always_ff @(posedge clk_line) begin
    if (clk_line_rst) begin
      state          <= WAIT_TUPLE;
      tuser_reg      <= '0;
      pkt_count      <= '0;
      tuple_overflow <= 1'b0;
      digest_missing <= 1'b0;
    end else begin
      state <= state_next;
      if (pop)                           tuser_reg      <= fifo_mem[rd_ptr];
      if (pkt_done)                      pkt_count      <= pkt_count + 32'd1;
      if (push && !push_accept)          tuple_overflow <= 1'b1;
      if (push && !tuple_digest_valid)   digest_missing <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Zero-latency data path; tuser is held for the whole packet
  // ---------------------------------------------------------------------------
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tlast = s_axis_tlast;
  assign m_axis_tuser = tuser_reg;

endmodule
